prio_encoder_8b: RTL and testbench
==================================

# prio_encoder_8b

Registered 8-bit priority encoder: reports the index of the highest-numbered asserted input bit, plus a valid flag that is set when any input bit is high. Sits between request/status vectors and downstream select/arbitration logic that needs a clean one-cycle-registered index. Bit 7 has the highest priority and bit 0 the lowest.

## Interface
- Parameters: none.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in  input  8  request vector; bit 7 highest priority, bit 0 lowest.
- out  output  3  binary index of the highest set bit of in, registered.
- valid  output  1  high when in was non-zero, registered.
- grant  output  8  one-hot form of out, registered; present only with PRIO_ENC_GRANT_EN.

## Operation
- The combinational core scans in from bit 7 down to bit 0. The first set bit found gives idx, and the core also forms any = |in.
- If any = 1, out_next = idx and valid_next = 1.
- If in = 8'h00, out_next = 3'd0 and valid_next = 0. Downstream logic must qualify out with valid, because out = 0 alone is ambiguous.
- Multiple set bits: only the highest index is reported; lower bits are ignored.
  - 8'b1001_0000 -> 7
  - 8'b0000_0011 -> 1
  - 8'hFF -> 7
- grant_next = (any) ? (8'b1 << idx) : 8'h00.
- No internal state other than the output registers. No handshake and no backpressure; a new vector is accepted every cycle.
- X/Z on in is not supported; the result is undefined.

## Timing
- Latency is 1 cycle. in sampled at rising edge N appears on out, valid and grant after edge N and holds until edge N+1.
- Throughput is 1 vector per cycle. Back-to-back changes are each reflected on the following edge.
- Reset: when rst_n = 0 at a rising edge, the next state is out = 3'd0, valid = 0, grant = 8'h00. Reset takes priority over in.
- Reset release: the first edge with rst_n = 1 samples in normally; results appear after that edge.
- Reset asserted mid-stream discards the in sampled on that edge. No pending result survives reset.
- Outputs are glitch-free: they change only on clk edges.

## Configuration
- Macro: PRIO_ENC_GRANT_EN.
- Defined: the grant[7:0] port and its register exist, and behave per Operation and Timing. grant is always either one-hot or zero, and always consistent with out and valid in the same cycle.
- Undefined: the grant port and its logic are absent. out and valid behave identically in both builds.

## Test plan
- Reset: drive rst_n = 0 with in = 8'hFF for 2 edges -> out = 0, valid = 0, grant = 8'h00. Then release, hold in = 8'hFF -> after the next edge out = 7, valid = 1, grant = 8'h80.
- Single-bit walk: drive in = 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01 on consecutive cycles -> out = 7, 6, 5, 4, 3, 2, 1, 0, each one cycle late, with valid = 1 throughout.
- Priority: in = 8'b1001_0000 -> out = 7. in = 8'b0001_0110 -> out = 4. in = 8'b0000_0011 -> out = 1. valid = 1 for all three.
- Zero and bit 0: in = 8'h00 -> out = 0, valid = 0, grant = 8'h00. Then in = 8'h01 -> out = 0, valid = 1, grant = 8'h01.
- Mid-stream reset: stream 8'h80, then 8'h40 with rst_n = 0 on that edge, then 8'h20 with rst_n = 1 -> outputs are 7/valid, then 0/invalid, then 5/valid.
- Exhaustive sweep: drive all 256 in values, compare each against a reference model with a 1-cycle delay. Run the sweep in builds both with and without PRIO_ENC_GRANT_EN.

Source files
------------

// File: rtl/prio_encoder_8b.sv
// Registered 8-bit priority encoder: index of the highest set bit plus a valid flag.
// Optional registered one-hot grant output when PRIO_ENC_GRANT_EN is defined.
module prio_encoder_8b (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in,
   output logic [2:0] out,
   output logic       valid
`ifdef PRIO_ENC_GRANT_EN
   ,
   output logic [7:0] grant
`endif
);

   logic [2:0] idx;
   logic       any;
   logic [2:0] out_d, out_q;
   logic       valid_d, valid_q;

   // Ascending scan: later (higher) set bits overwrite lower ones, so bit 7 wins.
   always_comb begin
      idx = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (in[i]) idx = 3'(i);
      end
      any     = |in;
      out_d   = any ? idx : '0;
      valid_d = any;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   assign out   = out_q;
   assign valid = valid_q;

`ifdef PRIO_ENC_GRANT_EN
   logic [7:0] grant_d, grant_q;

   always_comb begin
      grant_d = any ? (8'b1 << idx) : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) grant_q <= '0;
      else        grant_q <= grant_d;
   end

   assign grant = grant_q;
`endif

endmodule

// File: tb/tb_prio_encoder_8b.sv
// Directed plus exhaustive bench for prio_encoder_8b with a scoreboard queue.
// Builds with or without PRIO_ENC_GRANT_EN; grant is checked only when present.
module tb_prio_encoder_8b;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in;
   logic [2:0] out;
   logic       valid;
`ifdef PRIO_ENC_GRANT_EN
   logic [7:0] grant;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [2:0] o;
      logic       v;
      logic [7:0] g;
   } exp_t;

   exp_t sb[$];

   prio_encoder_8b dut (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (in),
      .out   (out),
      .valid (valid)
`ifdef PRIO_ENC_GRANT_EN
      ,
      .grant (grant)
`endif
   );

   always #5 clk = ~clk;

   // Reference: scan downward from bit 7, stop at the first set bit.
   function automatic exp_t model(input logic [7:0] v, input logic r);
      exp_t e;
      e = '0;
      if (r) begin
         for (int k = 7; k >= 0; k--) begin
            if (v[k]) begin
               e.o = 3'(k);
               e.v = 1'b1;
               e.g = 8'd1 << k;
               break;
            end
         end
      end
      return e;
   endfunction

   task automatic step(input logic [7:0] v, input logic r, input string tag);
      exp_t e;
      @(negedge clk);
      in    = v;
      rst_n = r;
      sb.push_back(model(v, r));
      @(posedge clk);
      #1;
      checks++;
      assert (sb.size() != 0) else begin
         errors++;
         $error("FAIL %s scoreboard empty got 0 exp 1", tag);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         checks++;
         assert (out === e.o) else begin
            errors++;
            $error("FAIL %s out got %0d exp %0d (in=%h)", tag, out, e.o, v);
         end
         checks++;
         assert (valid === e.v) else begin
            errors++;
            $error("FAIL %s valid got %0b exp %0b (in=%h)", tag, valid, e.v, v);
         end
`ifdef PRIO_ENC_GRANT_EN
         checks++;
         assert (grant === e.g) else begin
            errors++;
            $error("FAIL %s grant got %h exp %h (in=%h)", tag, grant, e.g, v);
         end
`endif
      end
   endtask

   logic [7:0] prio_vec [3] = '{8'b1001_0000, 8'b0001_0110, 8'b0000_0011};
   logic [7:0] w;

   initial begin
      rst_n = 1'b0;
      in    = 8'h00;

      step(8'hFF, 1'b0, "reset0");
      step(8'hFF, 1'b0, "reset1");
      step(8'hFF, 1'b1, "release");

      for (int i = 0; i < 8; i++) begin
         w = 8'h80 >> i;
         step(w, 1'b1, "walk");
      end

      for (int i = 0; i < 3; i++) step(prio_vec[i], 1'b1, "priority");

      step(8'h00, 1'b1, "zero");
      step(8'h01, 1'b1, "bit0");

      step(8'h80, 1'b1, "mid_pre");
      step(8'h40, 1'b0, "mid_rst");
      step(8'h20, 1'b1, "mid_post");

      for (int i = 0; i < 256; i++) step(8'(i), 1'b1, "sweep");
      for (int i = 255; i >= 0; i--) step(8'(i), 1'b1, "sweep_dn");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
